input_port_buffer: RTL and testbench

Per-port input stage of the NoC router. It accepts flits from the upstream link, stores them in a FIFO, and decodes the head flit with XY routing into a 3-bit output-port destination. It also requests the allocator and streams the packet into the crossbar switch over req/ack until the tail flit has gone. The router has five instances, one per port (LOCAL, WEST, NORTH, EAST, SOUTH); each drives one `buffers_rack_io` slot and one `dests` entry of the switch.

---
 rtl/noc_pkg.sv | 43 ++++
 rtl/flit_fifo.sv | 54 +++++
 rtl/input_port_buffer.sv | 95 +++++++++
 tb/tb_input_port_buffer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: output-port encoding, flit field layout and the XY
// routing function used by the router input ports and the network interface.
package noc_pkg;

    localparam int COORD_W = 4;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        EAST  = 3'd3,
        SOUTH = 3'd4
    } port_e;

    localparam logic [1:0] FLIT_BODY      = 2'b00;
    localparam logic [1:0] FLIT_HEAD      = 2'b01;
    localparam logic [1:0] FLIT_TAIL      = 2'b10;
    localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

    localparam int TYPE_LSB = 16;
    localparam int TYPE_MSB = 17;
    localparam int DX_LSB   = 4;
    localparam int DY_LSB   = 0;

    // Resolve X first, then Y; equal coordinates deliver locally.
    function automatic port_e xy_route(input logic [COORD_W-1:0] dest_x,
                                       input logic [COORD_W-1:0] dest_y,
                                       input logic [COORD_W-1:0] cur_x,
                                       input logic [COORD_W-1:0] cur_y);
        port_e p;
        if (dest_x > cur_x)      p = EAST;
        else if (dest_x < cur_x) p = WEST;
        else if (dest_y > cur_y) p = NORTH;
        else if (dest_y < cur_y) p = SOUTH;
        else                     p = LOCAL;
        return p;
    endfunction

    function automatic logic is_head_type(input logic [1:0] t);
        return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer with a registered occupancy count; rdata always shows
// the entry at the read pointer. Over-push and under-pop are ignored.
module flit_fifo #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/input_port_buffer.sv
// Router input port: buffers upstream flits, XY-routes the head flit, requests
// the allocator and streams the packet to the crossbar until its tail leaves.
module input_port_buffer
    import noc_pkg::*;
#(
    parameter int                  DATA_WIDTH = 18,
    parameter int                  DEPTH      = 4,
    parameter logic [COORD_W-1:0]  X_COORD    = '0,
    parameter logic [COORD_W-1:0]  Y_COORD    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_req,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ack,
    output logic                   sw_req,
    output logic [DATA_WIDTH-1:0]  sw_data,
    input  logic                   sw_ack,
    output logic [2:0]             dest,
    output logic                   alloc_req,
    input  logic                   grant,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} state_e;

    state_e                  state;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    empty;
    logic [DATA_WIDTH-1:0]   head;
    logic [1:0]              head_type;
    logic                    push;
    logic                    sw_pop;
    logic                    drop;
    port_e                   route;

    flit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (sw_pop || drop),
        .wdata (in_data),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign head_type = head[TYPE_MSB:TYPE_LSB];
    assign route     = xy_route(head[DX_LSB +: COORD_W], head[DY_LSB +: COORD_W],
                                X_COORD, Y_COORD);

    assign in_ack    = !full;
    assign push      = in_req && in_ack;
    assign sw_data   = head;
    assign sw_req    = (state == ROUTE) || ((state == ACTIVE) && !empty);
    assign alloc_req = (state != IDLE);
    // The switch already gates sw_ack by grant; requalifying keeps a stray ack
    // from draining a packet that holds no allocation.
    assign sw_pop    = sw_req && sw_ack && grant;
    assign drop      = (state == IDLE) && !empty && !is_head_type(head_type);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dest  <= 3'd0;
            err   <= 1'b0;
        end else begin
            err <= drop;
            case (state)
                IDLE: begin
                    if (!empty && is_head_type(head_type)) begin
                        dest  <= route;
                        state <= ROUTE;
                    end
                end
                ROUTE: begin
                    if (sw_pop)
                        state <= (head_type == FLIT_HEAD_TAIL) ? IDLE : ACTIVE;
                end
                ACTIVE: begin
                    // Stray heads mid-packet are streamed as body flits.
                    if (sw_pop && head_type == FLIT_TAIL)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer at router (1,1) with a 4-entry FIFO.
module tb_input_port_buffer;

    localparam int DW    = 18;
    localparam int DEPTH = 4;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_req = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ack;
    logic          sw_req;
    logic [DW-1:0] sw_data;
    logic          sw_ack = 1'b0;
    logic [2:0]    dest;
    logic          alloc_req;
    logic          grant = 1'b0;
    logic          err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    input_port_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .X_COORD    (4'd1),
        .Y_COORD    (4'd1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .sw_req    (sw_req),
        .sw_data   (sw_data),
        .sw_ack    (sw_ack),
        .dest      (dest),
        .alloc_req (alloc_req),
        .grant     (grant),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [15:0] p);
        return {t, p};
    endfunction

    function automatic logic [DW-1:0] mk_head(input logic [1:0] t, input logic [3:0] dx,
                                              input logic [3:0] dy);
        return {t, 8'h00, dx, dy};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // One HEAD_TAIL flit: IDLE after push, ROUTE next cycle, popped the cycle after.
    task automatic route_single(input logic [3:0] dx, input logic [3:0] dy,
                                input logic [2:0] exp_dest, input string tag);
        logic [DW-1:0] f;
        f = mk_head(T_HT, dx, dy);
        grant = 1'b1; sw_ack = 1'b1;
        in_req = 1'b1; in_data = f;
        step();
        in_req = 1'b0;
        check({tag, "_idle_swreq"}, 32'(sw_req), 32'd0);
        check({tag, "_head_data"}, 32'(sw_data), 32'(f));
        step();
        check({tag, "_route_swreq"}, 32'(sw_req), 32'd1);
        check({tag, "_route_alloc"}, 32'(alloc_req), 32'd1);
        check({tag, "_dest"}, 32'(dest), 32'(exp_dest));
        step();
        check({tag, "_popped_count"}, 32'(dut.count), 32'd0);
        check({tag, "_popped_alloc"}, 32'(alloc_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] pk [6];
        logic [10:0]   seen;

        // Reset
        step();
        check("rst_in_ack", 32'(in_ack), 32'd1);
        check("rst_sw_req", 32'(sw_req), 32'd0);
        check("rst_alloc", 32'(alloc_req), 32'd0);
        check("rst_dest", 32'(dest), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ack", 32'(in_ack), 32'd1);

        // Routing
        route_single(4'd2, 4'd1, 3'd3, "east");
        route_single(4'd0, 4'd1, 3'd1, "west");
        route_single(4'd1, 4'd3, 3'd2, "north");
        route_single(4'd1, 4'd0, 3'd4, "south");
        route_single(4'd1, 4'd1, 3'd0, "local");

        // Fill / backpressure
        grant = 1'b0; sw_ack = 1'b0;
        in_req = 1'b1; in_data = mk_head(T_HEAD, 4'd1, 4'd1); step();
        in_data = mk(T_BODY, 16'hB001); step();
        in_data = mk(T_BODY, 16'hB002); step();
        in_data = mk(T_TAIL, 16'hE003); step();
        check("fill_in_ack_full", 32'(in_ack), 32'd0);
        in_data = mk_head(T_HT, 4'd1, 4'd1); step();
        check("fill_count_held", 32'(dut.count), 32'd4);
        check("fill_in_ack_held", 32'(in_ack), 32'd0);
        check("fill_order_head", 32'(sw_data), 32'(mk_head(T_HEAD, 4'd1, 4'd1)));
        grant = 1'b1; sw_ack = 1'b1; step();
        check("fill_in_ack_back", 32'(in_ack), 32'd1);
        check("fill_order_b1", 32'(sw_data), 32'(mk(T_BODY, 16'hB001)));
        step();
        in_req = 1'b0;
        check("fill_order_b2", 32'(sw_data), 32'(mk(T_BODY, 16'hB002)));
        step();
        check("fill_order_tail", 32'(sw_data), 32'(mk(T_TAIL, 16'hE003)));
        step();
        check("fill_bubble_alloc", 32'(alloc_req), 32'd0);
        check("fill_fifth_head", 32'(sw_data), 32'(mk_head(T_HT, 4'd1, 4'd1)));
        step();
        check("fill_fifth_route", 32'(sw_req), 32'd1);
        step();
        check("fill_drained", 32'(dut.count), 32'd0);

        // Grant stall
        grant = 1'b0; sw_ack = 1'b0;
        in_req = 1'b1; in_data = mk_head(T_HEAD, 4'd2, 4'd1); step();
        in_data = mk(T_BODY, 16'h1234); step();
        in_data = mk(T_TAIL, 16'h5678); step();
        in_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_alloc", 32'(alloc_req), 32'd1);
            check("stall_sw_req", 32'(sw_req), 32'd1);
            check("stall_dest", 32'(dest), 32'd3);
            check("stall_count", 32'(dut.count), 32'd3);
            step();
        end
        grant = 1'b1; sw_ack = 1'b1;
        repeat (3) step();
        check("stall_drain_count", 32'(dut.count), 32'd0);
        check("stall_drain_alloc", 32'(alloc_req), 32'd0);

        // Back-to-back packets: WEST then SOUTH
        pk[0] = mk_head(T_HEAD, 4'd0, 4'd1);
        pk[1] = mk(T_BODY, 16'hAAAA);
        pk[2] = mk(T_TAIL, 16'hBBBB);
        pk[3] = mk_head(T_HEAD, 4'd1, 4'd0);
        pk[4] = mk(T_BODY, 16'hCCCC);
        pk[5] = mk(T_TAIL, 16'hDDDD);
        seen = '0;
        for (int k = 1; k <= 11; k++) begin
            in_req  = (k <= 6);
            in_data = (k <= 6) ? pk[k-1] : '0;
            step();
            seen[k-1] = alloc_req;
            if (k == 2) check("b2b_dest1", 32'(dest), 32'd1);
            if (k == 6) check("b2b_dest2", 32'(dest), 32'd4);
        end
        in_req = 1'b0;
        check("b2b_alloc_pattern", 32'(seen), 32'(11'b00011101110));

        // Error drop
        in_req = 1'b1; in_data = mk(T_BODY, 16'h0BAD); step();
        in_req = 1'b0;
        check("err_before", 32'(err), 32'd0);
        check("err_count_1", 32'(dut.count), 32'd1);
        check("err_no_swreq", 32'(sw_req), 32'd0);
        step();
        check("err_pulse", 32'(err), 32'd1);
        check("err_count_0", 32'(dut.count), 32'd0);
        check("err_no_swreq2", 32'(sw_req), 32'd0);
        step();
        check("err_cleared", 32'(err), 32'd0);

        // Mid-packet reset
        grant = 1'b0; sw_ack = 1'b0;
        in_req = 1'b1; in_data = mk_head(T_HEAD, 4'd2, 4'd1); step();
        in_data = mk(T_BODY, 16'h7777); step();
        in_req = 1'b0;
        check("mrst_pre_alloc", 32'(alloc_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_count", 32'(dut.count), 32'd0);
        check("mrst_sw_req", 32'(sw_req), 32'd0);
        check("mrst_alloc", 32'(alloc_req), 32'd0);
        check("mrst_in_ack", 32'(in_ack), 32'd1);
        check("mrst_dest", 32'(dest), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        route_single(4'd1, 4'd3, 3'd2, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
